// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment patterns, digit index type and score limit for the scan driver
package seg_pkg;
    typedef logic [1:0] digit_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGITS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] SCORE_MAX = 7'd99;
endpackage

// File: rtl/seg_scan_driver_decoder.sv
// seg_decoder: BCD digit to active-low {g,f,e,d,c,b,a}; blank flag or non-BCD input gives all segments off
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] pat
);
    assign pat = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_DIGITS[bcd];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed display of time (digits 1:0) and score (digits 3:2).
// Optional low-time blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] time_value,
    input  logic       tick_1hz,
    input  logic [6:0] score,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [CW-1:0] cnt;
    digit_t        idx;
    logic [4:0]    time_sh;
    logic [6:0]    score_sh;
    logic [6:0]    score_sat;
    logic [3:0]    t_ones, t_tens, s_ones, s_tens, bcd;
    logic          slot_end, blink, blank;
    logic [6:0]    pat;
    assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
    assign score_sat = score_sh > SCORE_MAX ? SCORE_MAX : score_sh;
    assign t_ones    = 4'(time_sh % 5'd10);
    assign t_tens    = 4'(time_sh / 5'd10);
    assign s_ones    = 4'(score_sat % 7'd10);
    assign s_tens    = 4'(score_sat / 7'd10);
    assign bcd       = idx == 2'd0 ? t_ones : idx == 2'd1 ? t_tens : idx == 2'd2 ? s_ones : s_tens;
    // Leading-zero suppression on tens digits, plus blinking of the time pair
    assign blank     = (idx == 2'd1 && t_tens == 4'd0) || (idx == 2'd3 && s_tens == 4'd0) ||
                       (blink && !idx[1]);
`ifdef SEG_BLINK_EN
    logic tick_q, blink_phase;
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q      <= 1'b0;
            blink_phase <= 1'b0;
        end else begin
            tick_q      <= tick_1hz;
            blink_phase <= blink_phase ^ (tick_1hz & ~tick_q);
        end
    end
    assign blink = blink_phase && time_sh >= 5'd1 && time_sh <= 5'd5;
`else
    logic unused_tick;
    assign unused_tick = tick_1hz;
    assign blink       = 1'b0;
`endif
    seg_decoder u_dec (.bcd(bcd), .blank(blank), .pat(pat));
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= 2'd0;
            time_sh  <= 5'd0;
            score_sh <= 7'd0;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
            an       <= 4'hF;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx + 1'b1;
            // New values enter only at a frame boundary so a frame never mixes old and new
            if (slot_end && idx == 2'd3) begin
                time_sh  <= time_value;
                score_sh <= score;
            end
            seg <= pat;
            dp  <= !(idx == 2'd2);
            an  <= blank ? 4'hF : ~(4'b0001 << idx);
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table vectors, corner sequences and a randomized run against a frame-level model
module tb_seg_scan_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] time_value = 5'd0;
    logic       tick_1hz = 1'b0;
    logic [6:0] score = 7'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    int checks = 0;
    int errors = 0;
    int n = 0;
    int ht [2048];
    int hs [2048];
    int hk [2048];
    logic [6:0] lit [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [3:0] scan [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    typedef struct {
        int t;
        int s;
        int d;
        logic [3:0] an;
        logic [6:0] seg;
        logic dp;
    } vec_t;
    vec_t vt [12];

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst(rst), .time_value(time_value), .tick_1hz(tick_1hz),
        .score(score), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected {an,seg,dp} after edge n: the slot and frame follow from n, the frame's
    // values are the inputs seen at the frame-start edge (zero for the first frame).
    function automatic logic [11:0] model();
        int d = ((n - 1) / 4) % 4;
        int f = (n - 1) / 16;
        int t = (f == 0) ? 0 : ht[16 * f];
        int s = (f == 0) ? 0 : hs[16 * f];
        int v;
        bit off;
        if (s > 99) s = 99;
        v = (d == 0) ? t % 10 : (d == 1) ? t / 10 : (d == 2) ? s % 10 : s / 10;
        off = (d % 2 == 1) && v == 0;
`ifdef SEG_BLINK_EN
        begin
            int ph = 0;
            for (int j = 1; j < n; j++)
                if (hk[j] != 0 && !(j > 1 && hk[j-1] != 0)) ph ^= 1;
            if (d < 2 && t >= 1 && t <= 5 && ph == 1) off = 1;
        end
`endif
        if (off) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << d), ~lit[v], (d == 2) ? 1'b0 : 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        n++;
        ht[n] = time_value;
        hs[n] = score;
        hk[n] = tick_1hz;
        @(negedge clk);
        chk($sformatf("model n=%0d", n), {4'h0, an, seg, dp}, {4'h0, model()});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset", {4'h0, an, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        n = 0;
        #1 chk("release", {4'h0, an, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
    endtask

    initial begin
        vt[0]  = '{23, 7,   0, 4'hE, 7'h30, 1'b1};
        vt[1]  = '{23, 7,   1, 4'hD, 7'h24, 1'b1};
        vt[2]  = '{23, 7,   2, 4'hB, 7'h78, 1'b0};
        vt[3]  = '{23, 7,   3, 4'hF, 7'h7F, 1'b1};
        vt[4]  = '{0,  120, 0, 4'hE, 7'h40, 1'b1};
        vt[5]  = '{0,  120, 1, 4'hF, 7'h7F, 1'b1};
        vt[6]  = '{0,  120, 2, 4'hB, 7'h10, 1'b0};
        vt[7]  = '{0,  120, 3, 4'h7, 7'h10, 1'b1};
        vt[8]  = '{31, 50,  0, 4'hE, 7'h79, 1'b1};
        vt[9]  = '{31, 50,  1, 4'hD, 7'h30, 1'b1};
        vt[10] = '{31, 50,  2, 4'hB, 7'h40, 1'b0};
        vt[11] = '{31, 50,  3, 4'h7, 7'h12, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            do_reset();
            time_value = 5'(vt[i].t);
            score = 7'(vt[i].s);
            tick_1hz = 1'b0;
            repeat (18 + 4 * vt[i].d) step();
            chk($sformatf("vec%0d", i), {4'h0, an, seg, dp}, {4'h0, vt[i].an, vt[i].seg, vt[i].dp});
        end
        do_reset();
        time_value = 5'd23;
        score = 7'd45;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k <= 4) chk("first_slot", {12'h0, an}, {12'h0, 4'hE});
            if (k > 16) chk("scan", {12'h0, an}, {12'h0, scan[((k - 1) / 4) % 4]});
        end
        do_reset();
        time_value = 5'd12;
        score = 7'd7;
        repeat (18) step();
        time_value = 5'd11;
        step();
        chk("hold_12", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h24, 1'b1});
        repeat (14) step();
        chk("show_11", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h79, 1'b1});
        do_reset();
        time_value = 5'd4;
        score = 7'd7;
        tick_1hz = 1'b0;
        repeat (17) step();
        chk("blink_pre", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h19, 1'b1});
        tick_1hz = 1'b1;
        repeat (2) step();
`ifdef SEG_BLINK_EN
        chk("blink_off", {4'h0, an, seg, dp}, {4'h0, 4'hF, 7'h7F, 1'b1});
`else
        chk("blink_off", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h19, 1'b1});
`endif
        tick_1hz = 1'b0;
        repeat (5) step();
        tick_1hz = 1'b1;
        step();
        chk("blink_score", {4'h0, an, seg, dp}, {4'h0, 4'hB, 7'h78, 1'b0});
        repeat (8) step();
        chk("blink_back", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h19, 1'b1});
        do_reset();
        time_value = 5'd23;
        score = 7'd45;
        repeat (26) step();
        chk("mid_digit2", {12'h0, an}, {12'h0, 4'hB});
        do_reset();
        step();
        chk("restart_d0", {12'h0, an}, {12'h0, 4'hE});
        time_value = 5'd3;
        for (int k = 0; k < 48; k++) begin
            if (k % 3 == 0) tick_1hz = ~tick_1hz;
            step();
`ifndef SEG_BLINK_EN
            if (n > 16 && ((n - 1) / 4) % 4 == 0)
                chk("no_blink", {4'h0, an, seg, dp}, {4'h0, 4'hE, 7'h30, 1'b1});
`endif
        end
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            if ($urandom_range(0, 9) == 0)
                time_value = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) score = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) tick_1hz = ~tick_1hz;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
